// File: rtl/loading_bar_screen_pkg.sv
// Shared OLED constants for the loading bar: colours, screen size, bar geometry, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package loading_bar_screen_pkg;

    // RGB565 palette
    localparam logic [15:0] WHITE      = 16'hFFFF;
    localparam logic [15:0] BLACK      = 16'h0000;
    localparam logic [15:0] LIGHTGREEN = 16'hAFE5;
    localparam logic [15:0] RED        = 16'hF800;
    localparam logic [15:0] GREEN      = 16'h07E0;
    localparam logic [15:0] BLUE       = 16'h001F;

    // 96x64 panel
    localparam int SCREEN_W = 96;
    localparam int SCREEN_H = 64;
    localparam int X_W      = 7;
    localparam int Y_W      = 6;
    localparam int PIX_W    = 16;

    // Bar outline: two 3-px side walls plus 3-px top and bottom rails.
    localparam int WALL_L_LO = 10;
    localparam int WALL_L_HI = 12;
    localparam int WALL_R_LO = 87;
    localparam int WALL_R_HI = 89;
    localparam int WALL_Y_LO = 29;
    localparam int WALL_Y_HI = 46;
    localparam int RAIL_X_LO = 13;
    localparam int RAIL_X_HI = 86;
    localparam int TOP_Y_LO  = 26;
    localparam int TOP_Y_HI  = 28;
    localparam int BOT_Y_LO  = 47;
    localparam int BOT_Y_HI  = 49;

    // Interior area that the segments tile.
    localparam int FILL_X_LO  = 14;
    localparam int FILL_X_HI  = 85;
    localparam int FILL_Y_LO  = 30;
    localparam int FILL_Y_HI  = 45;
    localparam int FILL_WIDTH = 72;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } bar_state_t;

    // First column of segment k out of n.
    function automatic int seg_lo(input int k, input int n);
        return FILL_X_LO + (k * FILL_WIDTH) / n;
    endfunction

    // Last column of segment k; one column before the next segment's start
    // is left as a background gap, and the last segment runs to the wall.
    function automatic int seg_hi(input int k, input int n);
        if (k == n - 1)
            return FILL_X_HI;
        return FILL_X_LO + ((k + 1) * FILL_WIDTH) / n - 2;
    endfunction

endpackage

// File: rtl/loading_bar_screen_if.sv
// Pixel-pipe and control bundle between game FSM / pixel mux and the loading bar.
// Latency: n/a (wires only).
// Backpressure: none; every input is sampled each cycle.
// master: frame_tick, start, abort, hold, x, y out; oled_data, busy, done, filled in.
// slave : the mirror image, used by loading_bar_screen.
interface loading_bar_screen_if
    import loading_bar_screen_pkg::*;
#(
    parameter int NUM_SEG = 4
);
    localparam int FILL_W = $clog2(NUM_SEG + 1);

    logic              frame_tick;
    logic              start;
    logic              abort;
    logic              hold;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [PIX_W-1:0]  oled_data;
    logic              busy;
    logic              done;
    logic [FILL_W-1:0] filled;

    modport master (
        output frame_tick, start, abort, hold, x, y,
        input  oled_data, busy, done, filled
    );

    modport slave (
        input  frame_tick, start, abort, hold, x, y,
        output oled_data, busy, done, filled
    );

endinterface

// File: rtl/loading_bar_pixel.sv
// Classifies a pixel (x, y) as outline, segment interior (with segment index), or neither.
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: x, y in; in_outline, in_seg, seg_idx out.
module loading_bar_pixel
    import loading_bar_screen_pkg::*;
#(
    parameter int NUM_SEG = 4,
    parameter int SEG_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
)(
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    output logic             in_outline,
    output logic             in_seg,
    output logic [SEG_W-1:0] seg_idx
);

    int xi;
    int yi;

    assign xi = int'(x);
    assign yi = int'(y);

    always_comb begin
        in_outline = 1'b0;
        if ((yi >= WALL_Y_LO) && (yi <= WALL_Y_HI) &&
            (((xi >= WALL_L_LO) && (xi <= WALL_L_HI)) ||
             ((xi >= WALL_R_LO) && (xi <= WALL_R_HI))))
            in_outline = 1'b1;
        if ((xi >= RAIL_X_LO) && (xi <= RAIL_X_HI) &&
            (((yi >= TOP_Y_LO) && (yi <= TOP_Y_HI)) ||
             ((yi >= BOT_Y_LO) && (yi <= BOT_Y_HI))))
            in_outline = 1'b1;
    end

    // Segment bounds are elaboration-time constants; the loop unrolls into
    // NUM_SEG independent range compares, at most one of which can hit.
    always_comb begin
        in_seg  = 1'b0;
        seg_idx = '0;
        if ((yi >= FILL_Y_LO) && (yi <= FILL_Y_HI)) begin
            for (int k = 0; k < NUM_SEG; k++) begin
                if ((xi >= seg_lo(k, NUM_SEG)) && (xi <= seg_hi(k, NUM_SEG))) begin
                    in_seg  = 1'b1;
                    seg_idx = SEG_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/loading_bar_screen.sv
// Animated loading bar: fills NUM_SEG segments on frame ticks, then blinks the full bar.
// Latency: oled_data 1 cycle after x/y; status outputs registered, 1 cycle after the causing input.
// Backpressure: none; frame_tick/start/abort/hold are sampled every cycle, hold only freezes counting.
// Ports: clk, rst_n (sync, active low); bus (slave): control in, oled_data/busy/done/filled out.
module loading_bar_screen
    import loading_bar_screen_pkg::*;
#(
    parameter int          NUM_SEG       = 4,
    parameter int          TICKS_PER_SEG = 30,
    parameter int          BLINK_FRAMES  = 15,
    parameter logic [15:0] FILL_COLOUR   = 16'hAFE5,
    parameter logic [15:0] FG_COLOUR     = 16'h0000,
    parameter logic [15:0] BG_COLOUR     = 16'hFFFF
)(
    input  logic              clk,
    input  logic              rst_n,
    loading_bar_screen_if.slave bus
);

    localparam int FILL_W  = $clog2(NUM_SEG + 1);
    localparam int SEG_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam int TICK_W  = (TICKS_PER_SEG > 1) ? $clog2(TICKS_PER_SEG) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_PER_SEG - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);
    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(NUM_SEG - 1);

    bar_state_t         state;
    logic [TICK_W-1:0]  tick_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [FILL_W-1:0]  filled;
    logic               blink_on;
    logic               busy;
    logic               done;
    logic [15:0]        oled_q;

    logic               in_outline;
    logic               in_seg;
    logic [SEG_W-1:0]   seg_idx;
    logic [15:0]        pix_colour;
    logic               tick_q;

    loading_bar_pixel #(
        .NUM_SEG (NUM_SEG),
        .SEG_W   (SEG_W)
    ) u_pixel (
        .x          (bus.x),
        .y          (bus.y),
        .in_outline (in_outline),
        .in_seg     (in_seg),
        .seg_idx    (seg_idx)
    );

    assign tick_q = bus.frame_tick && !bus.hold;

    always_comb begin
        pix_colour = BG_COLOUR;
        if (in_outline)
            pix_colour = FG_COLOUR;
        else if (in_seg && blink_on && (FILL_W'(seg_idx) < filled))
            pix_colour = FILL_COLOUR;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            blink_cnt <= '0;
            filled    <= '0;
            blink_on  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            oled_q    <= BG_COLOUR;
        end else begin
            done   <= 1'b0;
            // Pixel uses filled/blink_on as they stand before this edge's update.
            oled_q <= pix_colour;
            if (bus.abort) begin
                state     <= ST_IDLE;
                tick_cnt  <= '0;
                blink_cnt <= '0;
                filled    <= '0;
                blink_on  <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // A frame_tick in this same cycle is intentionally not counted.
                        if (bus.start) begin
                            state    <= ST_FILL;
                            busy     <= 1'b1;
                            tick_cnt <= '0;
                        end
                    end
                    ST_FILL: begin
                        if (tick_q) begin
                            if (tick_cnt == TICK_LAST) begin
                                tick_cnt <= '0;
                                filled   <= filled + FILL_W'(1);
                                if (filled == FILL_LAST) begin
                                    state     <= ST_DONE;
                                    busy      <= 1'b0;
                                    done      <= 1'b1;
                                    blink_on  <= 1'b1;
                                    blink_cnt <= '0;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + TICK_W'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        if (bus.start) begin
                            state     <= ST_FILL;
                            busy      <= 1'b1;
                            filled    <= '0;
                            tick_cnt  <= '0;
                            blink_cnt <= '0;
                            blink_on  <= 1'b1;
                        end else if (tick_q && (BLINK_FRAMES > 0)) begin
                            if (blink_cnt == BLINK_LAST) begin
                                blink_on  <= ~blink_on;
                                blink_cnt <= '0;
                            end else begin
                                blink_cnt <= blink_cnt + BLINK_W'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.oled_data = oled_q;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.filled    = filled;

endmodule

// File: tb/tb_loading_bar_screen.sv
module tb_loading_bar_screen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    loading_bar_screen_if #(.NUM_SEG(4))  if_a ();
    loading_bar_screen_if #(.NUM_SEG(18)) if_b ();

    loading_bar_screen #(
        .NUM_SEG(4), .TICKS_PER_SEG(30), .BLINK_FRAMES(15),
        .FILL_COLOUR(16'hAFE5), .FG_COLOUR(16'h0000), .BG_COLOUR(16'hFFFF)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));

    loading_bar_screen #(
        .NUM_SEG(18), .TICKS_PER_SEG(3), .BLINK_FRAMES(0),
        .FILL_COLOUR(16'hAFE5), .FG_COLOUR(16'h0000), .BG_COLOUR(16'hFFFF)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    int n_run = 0;
    int n_fail = 0;

    // Reference model: counts qualifying ticks rather than tracking counters.
    int ns  [2] = '{4, 18};
    int tps [2] = '{30, 3};
    int bf  [2] = '{15, 0};
    int m_mode [2];   // 0 idle, 1 filling, 2 full
    int m_q    [2];   // qualifying ticks since the fill started
    int m_b    [2];   // qualifying ticks since the bar became full
    bit m_done [2];
    int done_cnt [2];
    int dbl_cnt  [2];
    bit prev_done [2];

    function automatic int m_filled(input int d);
        if (m_mode[d] == 0) return 0;
        if (m_mode[d] == 2) return ns[d];
        return m_q[d] / tps[d];
    endfunction

    function automatic bit m_blink(input int d);
        if (m_mode[d] != 2 || bf[d] == 0) return 1'b1;
        return ((m_b[d] / bf[d]) % 2) == 0;
    endfunction

    function automatic logic [15:0] ref_pixel(input int d, input int px, input int py);
        bit band, inner, corner;
        band   = (px >= 10 && px <= 89 && py >= 26 && py <= 49);
        inner  = (px >= 13 && px <= 86 && py >= 29 && py <= 46);
        corner = (px < 13 || px > 86) && (py < 29 || py > 46);
        if (band && !inner && !corner) return 16'h0000;
        if (py >= 30 && py <= 45 && m_blink(d)) begin
            for (int k = 0; k < m_filled(d); k++) begin
                int lo, hi;
                lo = 14 + (k * 72) / ns[d];
                hi = (k == ns[d] - 1) ? 85 : 14 + ((k + 1) * 72) / ns[d] - 2;
                if (px >= lo && px <= hi) return 16'hAFE5;
            end
        end
        return 16'hFFFF;
    endfunction

    function automatic int get_filled(input int d);
        return (d == 0) ? int'(if_a.filled) : int'(if_b.filled);
    endfunction
    function automatic logic get_busy(input int d);
        return (d == 0) ? if_a.busy : if_b.busy;
    endfunction
    function automatic logic get_done(input int d);
        return (d == 0) ? if_a.done : if_b.done;
    endfunction
    function automatic logic [15:0] get_pix(input int d);
        return (d == 0) ? if_a.oled_data : if_b.oled_data;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_q[d] = 0; m_b[d] = 0; m_done[d] = 0; prev_done[d] = 0;
        end
    endtask

    // One clock with the given inputs on DUT d; model follows the same edge.
    task automatic step(input int d, input bit tk, input bit st, input bit ab, input bit hd);
        if (d == 0) begin
            if_a.frame_tick = tk; if_a.start = st; if_a.abort = ab; if_a.hold = hd;
        end else begin
            if_b.frame_tick = tk; if_b.start = st; if_b.abort = ab; if_b.hold = hd;
        end
        @(posedge clk);
        m_done[d] = 1'b0;
        if (ab) begin
            m_mode[d] = 0; m_q[d] = 0; m_b[d] = 0;
        end else if (st && m_mode[d] != 1) begin
            m_mode[d] = 1; m_q[d] = 0;
        end else if (tk && !hd) begin
            if (m_mode[d] == 1) begin
                m_q[d]++;
                if (m_q[d] == tps[d] * ns[d]) begin
                    m_mode[d] = 2; m_b[d] = 0; m_done[d] = 1'b1;
                end
            end else if (m_mode[d] == 2) begin
                m_b[d]++;
            end
        end
        #1;
        if (d == 0) begin
            if_a.frame_tick = 0; if_a.start = 0; if_a.abort = 0; if_a.hold = 0;
        end else begin
            if_b.frame_tick = 0; if_b.start = 0; if_b.abort = 0; if_b.hold = 0;
        end
        if (get_done(d)) done_cnt[d]++;
        if (get_done(d) && prev_done[d]) dbl_cnt[d]++;
        prev_done[d] = get_done(d);
    endtask

    task automatic ticks(input int d, input int n, input bit hd);
        for (int i = 0; i < n; i++) step(d, 1'b1, 1'b0, 1'b0, hd);
    endtask

    task automatic probe(input int d, input int px, input int py,
                         output logic [15:0] got, output logic [15:0] exp);
        exp = ref_pixel(d, px, py);
        if (d == 0) begin if_a.x = 7'(px); if_a.y = 6'(py); end
        else        begin if_b.x = 7'(px); if_b.y = 6'(py); end
        step(d, 1'b0, 1'b0, 1'b0, 1'b0);
        got = get_pix(d);
    endtask

    task automatic test_reset();
        logic [15:0] got, exp;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_run++; if (get_pix(d) !== 16'hFFFF) begin n_fail++; $display("FAIL reset_pix[%0d]: got %h want ffff", d, get_pix(d)); end
            n_run++; if (get_busy(d) !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", d, get_busy(d)); end
            n_run++; if (get_done(d) !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d]: got %b want 0", d, get_done(d)); end
            n_run++; if (get_filled(d) !== 0) begin n_fail++; $display("FAIL reset_filled[%0d]: got %0d want 0", d, get_filled(d)); end
        end
        rst_n = 1'b1;
        model_reset();
        for (int yy = 0; yy < 64; yy++)
            for (int xx = 0; xx < 96; xx++) begin
                probe(0, xx, yy, got, exp);
                n_run++;
                if (got !== exp) begin n_fail++; $display("FAIL scan(%0d,%0d): got %h want %h", xx, yy, got, exp); end
            end
        probe(0, 10, 29, got, exp);
        n_run++; if (got !== 16'h0000) begin n_fail++; $display("FAIL wall_px: got %h want 0000", got); end
        probe(0, 10, 28, got, exp);
        n_run++; if (got !== 16'hFFFF) begin n_fail++; $display("FAIL corner_px: got %h want ffff", got); end
        probe(0, 86, 49, got, exp);
        n_run++; if (got !== 16'h0000) begin n_fail++; $display("FAIL rail_px: got %h want 0000", got); end
    endtask

    task automatic test_first_segment();
        logic [15:0] got, exp;
        step(0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_run++; if (get_busy(0) !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b want 1", get_busy(0)); end
        ticks(0, 29, 1'b0);
        n_run++; if (get_filled(0) !== 0) begin n_fail++; $display("FAIL filled_29: got %0d want 0", get_filled(0)); end
        ticks(0, 1, 1'b0);
        n_run++; if (get_filled(0) !== 1) begin n_fail++; $display("FAIL filled_30: got %0d want 1", get_filled(0)); end
        probe(0, 20, 35, got, exp);
        n_run++; if (got !== 16'hAFE5 || exp !== 16'hAFE5) begin n_fail++; $display("FAIL seg0_px: got %h want afe5", got); end
        probe(0, 31, 35, got, exp);
        n_run++; if (got !== 16'hFFFF) begin n_fail++; $display("FAIL gap_px: got %h want ffff", got); end
        probe(0, 40, 35, got, exp);
        n_run++; if (got !== 16'hFFFF) begin n_fail++; $display("FAIL seg1_px: got %h want ffff", got); end
        step(0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_run++; if (get_filled(0) !== 1 || get_busy(0) !== 1'b1) begin n_fail++; $display("FAIL start_in_fill: got filled %0d busy %b want 1 1", get_filled(0), get_busy(0)); end
    endtask

    task automatic test_done_blink();
        logic [15:0] got, exp;
        int d0;
        step(0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0, 1'b0);
        d0 = done_cnt[0];
        ticks(0, 119, 1'b0);
        n_run++; if (get_done(0) !== 1'b0) begin n_fail++; $display("FAIL done_early: got %b want 0", get_done(0)); end
        ticks(0, 1, 1'b0);
        n_run++; if (get_done(0) !== 1'b1 || get_filled(0) !== 4) begin n_fail++; $display("FAIL done_pulse: got done %b filled %0d want 1 4", get_done(0), get_filled(0)); end
        n_run++; if (get_busy(0) !== 1'b0) begin n_fail++; $display("FAIL busy_done: got %b want 0", get_busy(0)); end
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_run++; if (get_done(0) !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b want 0", get_done(0)); end
        n_run++; if (done_cnt[0] - d0 !== 1) begin n_fail++; $display("FAIL done_count: got %0d want 1", done_cnt[0] - d0); end
        ticks(0, 14, 1'b0);
        probe(0, 50, 35, got, exp);
        n_run++; if (got !== 16'hAFE5) begin n_fail++; $display("FAIL blink_14: got %h want afe5", got); end
        ticks(0, 1, 1'b0);
        probe(0, 50, 35, got, exp);
        n_run++; if (got !== 16'hFFFF) begin n_fail++; $display("FAIL blink_off: got %h want ffff", got); end
        ticks(0, 15, 1'b0);
        probe(0, 50, 35, got, exp);
        n_run++; if (got !== 16'hAFE5) begin n_fail++; $display("FAIL blink_on: got %h want afe5", got); end
        step(0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_run++; if (get_busy(0) !== 1'b1 || get_filled(0) !== 0) begin n_fail++; $display("FAIL restart: got busy %b filled %0d want 1 0", get_busy(0), get_filled(0)); end
    endtask

    task automatic test_abort_start();
        ticks(0, 60, 1'b0);
        n_run++; if (get_filled(0) !== 2) begin n_fail++; $display("FAIL pre_abort: got %0d want 2", get_filled(0)); end
        step(0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_run++; if (get_busy(0) !== 1'b0 || get_filled(0) !== 0) begin n_fail++; $display("FAIL abort_start: got busy %b filled %0d want 0 0", get_busy(0), get_filled(0)); end
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_run++; if (get_busy(0) !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b want 0", get_busy(0)); end
    endtask

    task automatic test_start_tick_hold();
        step(0, 1'b1, 1'b1, 1'b0, 1'b0);
        ticks(0, 29, 1'b0);
        n_run++; if (get_filled(0) !== 0) begin n_fail++; $display("FAIL start_tick: got %0d want 0", get_filled(0)); end
        ticks(0, 1, 1'b0);
        n_run++; if (get_filled(0) !== 1) begin n_fail++; $display("FAIL start_tick_seg: got %0d want 1", get_filled(0)); end
        ticks(0, 40, 1'b1);
        n_run++; if (get_filled(0) !== 1) begin n_fail++; $display("FAIL hold: got %0d want 1", get_filled(0)); end
        ticks(0, 30, 1'b0);
        n_run++; if (get_filled(0) !== 2) begin n_fail++; $display("FAIL hold_release: got %0d want 2", get_filled(0)); end
        step(0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_run++; if (get_filled(0) !== 0 || get_busy(0) !== 1'b0) begin n_fail++; $display("FAIL hold_abort: got filled %0d busy %b want 0 0", get_filled(0), get_busy(0)); end
    endtask

    task automatic test_reset_mid_fill();
        step(0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(0, 35, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        n_run++; if (get_filled(0) !== 0 || get_busy(0) !== 1'b0 || get_pix(0) !== 16'hFFFF) begin
            n_fail++; $display("FAIL mid_reset: got filled %0d busy %b pix %h want 0 0 ffff", get_filled(0), get_busy(0), get_pix(0));
        end
        rst_n = 1'b1;
    endtask

    task automatic test_seg18();
        logic [15:0] got, exp;
        int d0;
        step(1, 1'b0, 1'b1, 1'b0, 1'b0);
        d0 = done_cnt[1];
        ticks(1, 54, 1'b0);
        n_run++; if (get_done(1) !== 1'b1 || get_filled(1) !== 18) begin n_fail++; $display("FAIL s18_done: got done %b filled %0d want 1 18", get_done(1), get_filled(1)); end
        probe(1, 82, 35, got, exp);
        n_run++; if (got !== 16'hAFE5) begin n_fail++; $display("FAIL s18_lo: got %h want afe5", got); end
        probe(1, 85, 45, got, exp);
        n_run++; if (got !== 16'hAFE5) begin n_fail++; $display("FAIL s18_hi: got %h want afe5", got); end
        probe(1, 81, 35, got, exp);
        n_run++; if (got !== 16'hFFFF) begin n_fail++; $display("FAIL s18_gap: got %h want ffff", got); end
        for (int i = 0; i < 4; i++) begin
            ticks(1, 10, 1'b0);
            probe(1, 83, 40, got, exp);
            n_run++; if (got !== 16'hAFE5) begin n_fail++; $display("FAIL s18_steady%0d: got %h want afe5", i, got); end
        end
        n_run++; if (done_cnt[1] - d0 !== 1) begin n_fail++; $display("FAIL s18_done_cnt: got %0d want 1", done_cnt[1] - d0); end
    endtask

    task automatic test_random(input int d, input int cycles);
        logic [15:0] got, exp;
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            if (i % 8 == 7) begin
                probe(d, int'($urandom_range(91, 8)), int'($urandom_range(51, 24)), got, exp);
                n_run++; if (got !== exp) begin n_fail++; $display("FAIL rnd_pix[%0d] cyc %0d: got %h want %h", d, i, got, exp); end
            end else begin
                step(d, ($urandom % 3) == 0, ($urandom % 25) == 0, ($urandom % 150) == 0, ($urandom % 5) == 0);
            end
            n_run++;
            if (get_filled(d) !== m_filled(d) || get_busy(d) !== (m_mode[d] == 1) || get_done(d) !== m_done[d]) begin
                n_fail++;
                $display("FAIL rnd_state[%0d] cyc %0d: got f%0d b%b d%b want f%0d b%b d%b", d, i,
                         get_filled(d), get_busy(d), get_done(d), m_filled(d), m_mode[d] == 1, m_done[d]);
            end
        end
        n_run++; if (dbl_cnt[d] !== 0) begin n_fail++; $display("FAIL done_double[%0d]: got %0d want 0", d, dbl_cnt[d]); end
    endtask

    initial begin
        if_a.frame_tick = 0; if_a.start = 0; if_a.abort = 0; if_a.hold = 0; if_a.x = '0; if_a.y = '0;
        if_b.frame_tick = 0; if_b.start = 0; if_b.abort = 0; if_b.hold = 0; if_b.x = '0; if_b.y = '0;
        for (int d = 0; d < 2; d++) begin done_cnt[d] = 0; dbl_cnt[d] = 0; end
        model_reset();
        test_reset();
        test_first_segment();
        test_done_blink();
        test_abort_start();
        test_start_tick_hold();
        test_reset_mid_fill();
        test_seg18();
        test_random(0, 3000);
        test_random(1, 800);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
